ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one combinational add/multiply ALU (16-bit operands e0/e1, select h: 0 = add, 1 = multiply, 16-bit truncated result s) between two requesters.
- Accepts one operation per cycle from the granted requester and drives the ALU operand/select lines.
- Captures the ALU result into a one-entry output register tagged with the requester ID, and holds it under valid/ready backpressure.
- Keeps per-requester completed-operation counters for debug.

Parameters:
- W, 16, operand/result width; must match the ALU width.
- CW, 8, width of each per-requester completion counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  W  requester 0 operand A.
- req0_b  input  W  requester 0 operand B.
- req0_op  input  1  requester 0 op: 0 add, 1 multiply.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_e0  output  W  ALU operand A.
- alu_e1  output  W  ALU operand B.
- alu_h  output  1  ALU op select.
- alu_s  input  W  ALU result (combinational from alu_e0/alu_e1/alu_h).
- resp_valid  output  1  result register holds a result.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  W  result.
- resp_id  output  1  requester that issued the result.
- cnt0  output  CW  completed ops for requester 0.
- cnt1  output  CW  completed ops for requester 1.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - resp_valid = 0, resp_data = 0, resp_id = 0.
  - cnt0 = cnt1 = 0.
  - last_grant = 1, so requester 0 wins the first conflict.
- State machine (2 states):
  - EMPTY: output register free.
  - FULL: output register holds an unconsumed result.
  - resp_valid = (state == FULL).
- can_accept = EMPTY, or (FULL and resp_ready). A drain and a new accept in the same cycle give full throughput of 1 op/cycle.
- Grant (combinational), evaluated only when can_accept:
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - Neither high: no grant.
- reqN_ready = can_accept and grant == N. At most one ready is high per cycle, and ready never depends on the requester's own valid being low.
- ALU drive:
  - alu_e0/alu_e1/alu_h = granted requester's a/b/op.
  - With no grant, they hold requester 0's inputs (a don't-care, but deterministic, no X).
- Accept (reqN_valid and reqN_ready) at edge:
  - resp_data <= alu_s; resp_id <= N; last_grant <= N.
  - cntN <= cntN + 1; CW-bit wrap, 2^CW-1 -> 0.
  - State -> FULL.
- Latency: result visible on resp_data with resp_valid = 1 the cycle after acceptance.
- FULL and resp_ready with no accept: state -> EMPTY; resp_data/resp_id hold their stale values.
- FULL and not resp_ready: resp_valid, resp_data and resp_id stable; no ready asserted.
- Counters increment on accept, not on drain. A result counts once accepted.
- Arithmetic: the result is the ALU's truncated W-bit value. The arbiter never modifies it, and overflow is not flagged.
- Reset mid-operation: rst in any state returns to EMPTY with the reset values above. A held result is discarded, and ready is low during the reset cycle.
- Requesters must hold valid/a/b/op stable until accepted. The arbiter does not register operands before grant.

Test Plan:
- Reset, then req0 a=3 b=2 op=0, resp_ready=1 -> req0_ready=1 in cycle 0; cycle 1 resp_valid=1, resp_data=5, resp_id=0, cnt0=1.
- Both valid every cycle, req0 (3,3,mul), req1 (3,2,add), resp_ready=1 -> grants alternate 0,1,0,1; results 9,5,9,5 with ids 0,1,0,1; one result per cycle.
- resp_ready=0 for 3 cycles after the first result -> resp_valid stays 1 and data stable; both readies low; on resp_ready=1 the next grant lands in the same cycle and the new result follows the next cycle.
- Overflow: req1 a=16'hFFFF b=2 op=1 -> resp_data=16'hFFFE; a=16'hFFFF b=1 op=0 -> resp_data=0.
- Counter wrap: 256 accepted req0 ops with CW=8 -> cnt0 returns to 0; cnt1 unaffected.
- Assert rst while FULL with resp_ready=0 -> next cycle resp_valid=0, counters 0; first subsequent conflict granted to requester 0.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// Requester, ALU and response signal bundle for ula_arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface ula_arbiter_if #(
    parameter int W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_op;
    logic [W-1:0] alu_e0;
    logic [W-1:0] alu_e1;
    logic         alu_h;
    logic [W-1:0] alu_s;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_e0, alu_e1, alu_h,
        input  alu_s,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_e0, alu_e1, alu_h,
        output alu_s,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );
endinterface

// File: rtl/ula_arbiter.sv
// Two-requester round-robin arbiter sharing one combinational add/mul ALU,
// with a one-entry tagged result register and per-requester completion counters.
module ula_arbiter #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    ula_arbiter_if.slave  bus,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t       state, state_n;
    logic         last_grant;
    logic         can_accept;
    logic         gnt_valid;
    logic         gnt_id;
    logic [W-1:0] data_q;
    logic         id_q;

    always_comb begin
        state_n    = state;
        can_accept = 1'b0;
        gnt_valid  = 1'b0;
        gnt_id     = 1'b0;

        // Ready is forced low while rst is asserted.
        if (!rst) begin
            can_accept = (state == EMPTY) || bus.resp_ready;
        end

        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end

        if (gnt_valid) begin
            state_n = FULL;
        end else if (state == FULL && bus.resp_ready) begin
            state_n = EMPTY;
        end

        bus.req0_ready = gnt_valid && !gnt_id;
        bus.req1_ready = gnt_valid && gnt_id;

        // Idle ALU inputs follow requester 0 so they are never X.
        if (gnt_valid && gnt_id) begin
            bus.alu_e0 = bus.req1_a;
            bus.alu_e1 = bus.req1_b;
            bus.alu_h  = bus.req1_op;
        end else begin
            bus.alu_e0 = bus.req0_a;
            bus.alu_e1 = bus.req0_b;
            bus.alu_h  = bus.req0_op;
        end

        bus.resp_valid = (state == FULL);
        bus.resp_data  = data_q;
        bus.resp_id    = id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            data_q     <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            state <= state_n;
            if (gnt_valid) begin
                data_q     <= bus.alu_s;
                id_q       <= gnt_id;
                last_grant <= gnt_id;
                if (gnt_id) begin
                    cnt1 <= cnt1 + CW'(1);
                end else begin
                    cnt0 <= cnt0 + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: scripted scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_ula_arbiter;
    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cnt0, cnt1;
    int            checks = 0;
    int            errors = 0;

    // Reference model state
    logic          m_full;
    logic          m_last;
    logic [W-1:0]  m_data;
    logic          m_id;
    logic [CW-1:0] m_c0, m_c1;

    ula_arbiter_if #(.W(W)) bus ();

    ula_arbiter #(.W(W), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic op);
        logic [2*W-1:0] p;
        logic [W-1:0]   s;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        s = a + b;
        return op ? p[W-1:0] : s;
    endfunction

    // The ALU is external to the arbiter; the bench provides it.
    assign bus.alu_s = ref_alu(bus.alu_e0, bus.alu_e1, bus.alu_h);

    task automatic model_grant(output logic gv, output logic gid);
        gv  = 1'b0;
        gid = 1'b0;
        if (!rst && (!m_full || bus.resp_ready)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gv = 1'b1; gid = !m_last;
            end else if (bus.req0_valid) begin
                gv = 1'b1; gid = 1'b0;
            end else if (bus.req1_valid) begin
                gv = 1'b1; gid = 1'b1;
            end
        end
    endtask

    // Advance one clock and update the model from the current inputs.
    task automatic step();
        logic gv, gid;
        logic [W-1:0] res;
        model_grant(gv, gid);
        res = gid ? ref_alu(bus.req1_a, bus.req1_b, bus.req1_op)
                  : ref_alu(bus.req0_a, bus.req0_b, bus.req0_op);
        @(posedge clk);
        #1;
        if (rst) begin
            m_full = 1'b0; m_last = 1'b1; m_data = '0; m_id = 1'b0; m_c0 = '0; m_c1 = '0;
        end else if (gv) begin
            m_full = 1'b1; m_data = res; m_id = gid; m_last = gid;
            if (gid) m_c1 = m_c1 + 1'b1;
            else     m_c0 = m_c0 + 1'b1;
        end else if (bus.resp_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    task automatic idle();
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        drive0(1'b1, 16'd1, 16'd1, 1'b0);
        drive1(1'b1, 16'd2, 16'd2, 1'b0);
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
        end
        step();
        step();
        rst = 1'b0;
        idle();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'd0 || bus.resp_id !== 1'b0) begin
            errors++; $display("FAIL reset_resp: got v=%b d=%h id=%b expected v=0 d=0000 id=0",
                               bus.resp_valid, bus.resp_data, bus.resp_id);
        end
        checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1);
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive0(1'b1, 16'd3, 16'd2, 1'b0);
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++; $display("FAIL basic_ready: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
        end
        checks++;
        if (bus.alu_e0 !== 16'd3 || bus.alu_e1 !== 16'd2 || bus.alu_h !== 1'b0) begin
            errors++; $display("FAIL basic_alu: got %h %h %b expected 0003 0002 0",
                               bus.alu_e0, bus.alu_e1, bus.alu_h);
        end
        step();
        drive0(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 16'd5 || bus.resp_id !== 1'b0 || cnt0 !== 8'd1) begin
            errors++; $display("FAIL basic_resp: got v=%b d=%0d id=%b c0=%0d expected v=1 d=5 id=0 c0=1",
                               bus.resp_valid, bus.resp_data, bus.resp_id, cnt0);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        drive0(1'b1, 16'd3, 16'd3, 1'b1);
        drive1(1'b1, 16'd3, 16'd2, 1'b0);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL alt_grant[%0d]: got %b%b expected %b%b", i,
                                   bus.req0_ready, bus.req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            step();
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== ((i % 2 == 1) ? 16'd5 : 16'd9)
                || bus.resp_id !== (i % 2 == 1)) begin
                errors++; $display("FAIL alt_resp[%0d]: got v=%b d=%0d id=%b", i,
                                   bus.resp_valid, bus.resp_data, bus.resp_id);
            end
        end
        checks++;
        if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin
            errors++; $display("FAIL alt_cnt: got %0d/%0d expected 2/2", cnt0, cnt1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive0(1'b1, 16'd3, 16'd3, 1'b1);
        drive1(1'b1, 16'd3, 16'd2, 1'b0);
        bus.resp_ready = 1'b1;
        #1;
        step();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.resp_valid !== 1'b1
                || bus.resp_data !== 16'd9 || bus.resp_id !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got r=%b%b v=%b d=%0d id=%b expected r=00 v=1 d=9 id=0",
                                   i, bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_data, bus.resp_id);
            end
            step();
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_grant: got %b%b expected 01", bus.req0_ready, bus.req1_ready);
        end
        step();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 16'd5 || bus.resp_id !== 1'b1) begin
            errors++; $display("FAIL bp_release_resp: got v=%b d=%0d id=%b expected v=1 d=5 id=1",
                               bus.resp_valid, bus.resp_data, bus.resp_id);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive1(1'b1, 16'hFFFF, 16'd2, 1'b1);
        bus.resp_ready = 1'b1;
        #1;
        step();
        checks++;
        if (bus.resp_data !== 16'hFFFE || bus.resp_id !== 1'b1) begin
            errors++; $display("FAIL ovf_mul: got %h id=%b expected fffe id=1", bus.resp_data, bus.resp_id);
        end
        drive1(1'b1, 16'hFFFF, 16'd1, 1'b0);
        #1;
        step();
        checks++;
        if (bus.resp_data !== 16'h0000 || cnt1 !== 8'd2) begin
            errors++; $display("FAIL ovf_add: got %h c1=%0d expected 0000 c1=2", bus.resp_data, cnt1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive0(1'b1, W'($urandom), W'($urandom), 1'($urandom));
            #1;
            step();
            checks++;
            if (cnt0 !== m_c0 || bus.resp_data !== m_data) begin
                errors++; $display("FAIL wrap_step[%0d]: got c0=%0d d=%h expected c0=%0d d=%h",
                                   i, cnt0, bus.resp_data, m_c0, m_data);
            end
        end
        drive0(1'b0, '0, '0, 1'b0);
        checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL wrap_final: got %0d/%0d expected 0/0", cnt0, cnt1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive0(1'b1, 16'd7, 16'd8, 1'b1);
        bus.resp_ready = 1'b1;
        #1;
        step();
        bus.resp_ready = 1'b0;
        drive1(1'b1, 16'd1, 16'd1, 1'b0);
        #1;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
        end
        step();
        rst = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL rstmid_state: got v=%b c=%0d/%0d expected v=0 c=0/0",
                               bus.resp_valid, cnt0, cnt1);
        end
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_conflict: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
        end
        step();
        checks++;
        if (bus.resp_id !== 1'b0 || bus.resp_data !== 16'd56) begin
            errors++; $display("FAIL rstmid_resp: got id=%b d=%0d expected id=0 d=56", bus.resp_id, bus.resp_data);
        end
    endtask

    task automatic test_random();
        logic gv, gid;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (!bus.req0_valid && $urandom_range(1, 0) == 1)
                drive0(1'b1, W'($urandom), W'($urandom_range(15, 0)), 1'($urandom));
            if (!bus.req1_valid && $urandom_range(1, 0) == 1)
                drive1(1'b1, W'($urandom), W'($urandom_range(15, 0)), 1'($urandom));
            bus.resp_ready = ($urandom_range(3, 0) != 0);
            #1;
            model_grant(gv, gid);
            checks++;
            if (bus.req0_ready !== (gv && !gid) || bus.req1_ready !== (gv && gid)) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", n,
                                   bus.req0_ready, bus.req1_ready, gv && !gid, gv && gid);
            end
            checks++;
            if (gv && gid) begin
                if (bus.alu_e0 !== bus.req1_a || bus.alu_e1 !== bus.req1_b || bus.alu_h !== bus.req1_op) begin
                    errors++; $display("FAIL rand_alu1[%0d]: got %h %h %b", n, bus.alu_e0, bus.alu_e1, bus.alu_h);
                end
            end else if (bus.alu_e0 !== bus.req0_a || bus.alu_e1 !== bus.req0_b || bus.alu_h !== bus.req0_op) begin
                errors++; $display("FAIL rand_alu0[%0d]: got %h %h %b", n, bus.alu_e0, bus.alu_e1, bus.alu_h);
            end
            step();
            checks++;
            if (bus.resp_valid !== m_full || (m_full && (bus.resp_data !== m_data || bus.resp_id !== m_id))) begin
                errors++; $display("FAIL rand_resp[%0d]: got v=%b d=%h id=%b expected v=%b d=%h id=%b", n,
                                   bus.resp_valid, bus.resp_data, bus.resp_id, m_full, m_data, m_id);
            end
            checks++;
            if (cnt0 !== m_c0 || cnt1 !== m_c1) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, cnt0, cnt1, m_c0, m_c1);
            end
            if (gv && !gid) bus.req0_valid = 1'b0;
            if (gv && gid)  bus.req1_valid = 1'b0;
        end
    endtask

    initial begin
        m_full = 1'b0; m_last = 1'b1; m_data = '0; m_id = 1'b0; m_c0 = '0; m_c1 = '0;
        rst = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
